// File: rtl/ahb_slave_arbiter_pkg.sv
// AHB transfer/burst encodings shared by the slave-port arbiter.
// burst_len gives the beat count of a burst; undefined-length INCR counts as 1.
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_type;

    function automatic logic [4:0] burst_len(hburst_type b);
        logic [4:0] len;
        case (b)
            HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
// Zero latency; no backpressure, pure function of its inputs.
module ahb_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] id_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        // The pointer holder itself is scanned last, so it only wins when alone.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = IW'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter holding grant across bursts (and hmastlock with AHB_ARB_HMASTLOCK_EN).
// Grant one cycle after request when free; all state frozen while hready=0, losers stalled.
module ahb_slave_arbiter
    import AHB_package::*;
#(
    parameter int MASTER_NUM = 4
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [MASTER_NUM-1:0]         hreq,
    input  logic [2*MASTER_NUM-1:0]       htrans_m,
    input  logic [3*MASTER_NUM-1:0]       hburst_m,
    input  logic                          hready,
`ifdef AHB_ARB_HMASTLOCK_EN
    input  logic [MASTER_NUM-1:0]         hmastlock_m,
`endif
    output logic [MASTER_NUM-1:0]         hgrant,
    output logic                          hsel_slv,
    output logic [$clog2(MASTER_NUM)-1:0] addr_master_id,
    output logic [$clog2(MASTER_NUM)-1:0] data_master_id,
    output logic                          data_valid,
    output logic [MASTER_NUM-1:0]         master_stall
);
    localparam int ID_W = $clog2(MASTER_NUM);

    logic [MASTER_NUM-1:0] hgrant_q, hgrant_d;
    logic [ID_W-1:0]       addr_id_q, addr_id_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       data_id_q, data_id_d;
    logic                  dvld_q, dvld_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  incr_q, incr_d;
`ifdef AHB_ARB_HMASTLOCK_EN
    logic                  mlock_q, mlock_d;
`endif

    logic                  granted, own_req, accepted, locked_nxt;
    htrans_type            own_trans;
    hburst_type            own_burst;
    logic [MASTER_NUM-1:0] pick_oh;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;

    ahb_rr_picker #(.N(MASTER_NUM)) u_picker (
        .req_i   (hreq),
        .ptr_i   (rr_q),
        .grant_o (pick_oh),
        .id_o    (pick_id),
        .any_o   (pick_any)
    );

    assign granted   = |hgrant_q;
    assign own_req   = hreq[addr_id_q];
    assign own_trans = htrans_type'(htrans_m[2*int'(addr_id_q) +: 2]);
    assign own_burst = hburst_type'(hburst_m[3*int'(addr_id_q) +: 3]);
    assign accepted  = hready & granted & own_req &
                       ((own_trans == HTRANS_NONSEQ) | (own_trans == HTRANS_SEQ));

    always_comb begin
        hgrant_d   = hgrant_q;
        addr_id_d  = addr_id_q;
        rr_d       = rr_q;
        data_id_d  = data_id_q;
        dvld_d     = dvld_q;
        cnt_d      = cnt_q;
        incr_d     = incr_q;
        locked_nxt = 1'b0;
`ifdef AHB_ARB_HMASTLOCK_EN
        mlock_d    = mlock_q;
`endif
        if (hready) begin
            // BUSY is checked before hreq so a pausing burst owner keeps the slave.
            if (!granted || own_trans == HTRANS_IDLE) begin
                cnt_d  = '0;
                incr_d = 1'b0;
            end else if (own_trans == HTRANS_BUSY) begin
                cnt_d  = cnt_q;
                incr_d = incr_q;
            end else if (!own_req) begin
                cnt_d  = '0;
                incr_d = 1'b0;
            end else if (own_trans == HTRANS_NONSEQ) begin
                cnt_d  = 4'(burst_len(own_burst) - 5'd1);
                incr_d = (own_burst == HBURST_INCR);
            end else begin
                cnt_d  = (cnt_q == 4'd0) ? 4'd0 : 4'(cnt_q - 4'd1);
            end

`ifdef AHB_ARB_HMASTLOCK_EN
            if (!granted || own_trans == HTRANS_IDLE || !hmastlock_m[addr_id_q])
                mlock_d = 1'b0;
            else if (accepted)
                mlock_d = 1'b1;
            locked_nxt = (cnt_d != 4'd0) | incr_d | mlock_d;
`else
            locked_nxt = (cnt_d != 4'd0) | incr_d;
`endif

            if (!locked_nxt) begin
                if (pick_any) begin
                    hgrant_d  = pick_oh;
                    addr_id_d = pick_id;
                    rr_d      = pick_id;
                end else begin
                    hgrant_d  = '0;
                end
            end

            dvld_d = accepted;
            if (accepted)
                data_id_d = addr_id_q;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hgrant_q  <= '0;
            addr_id_q <= '0;
            rr_q      <= ID_W'(MASTER_NUM - 1);
            data_id_q <= '0;
            dvld_q    <= 1'b0;
            cnt_q     <= '0;
            incr_q    <= 1'b0;
`ifdef AHB_ARB_HMASTLOCK_EN
            mlock_q   <= 1'b0;
`endif
        end else begin
            hgrant_q  <= hgrant_d;
            addr_id_q <= addr_id_d;
            rr_q      <= rr_d;
            data_id_q <= data_id_d;
            dvld_q    <= dvld_d;
            cnt_q     <= cnt_d;
            incr_q    <= incr_d;
`ifdef AHB_ARB_HMASTLOCK_EN
            mlock_q   <= mlock_d;
`endif
        end
    end

    assign hgrant         = hgrant_q;
    assign hsel_slv       = granted & own_req;
    assign addr_master_id = addr_id_q;
    assign data_master_id = data_id_q;
    assign data_valid     = dvld_q;
    assign master_stall   = hreq & ~hgrant_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter: round-robin grant, burst holding, wait states, reset.
// hmastlock scenario is compiled only with AHB_ARB_HMASTLOCK_EN.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011, INCR8 = 3'b101;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [3:0]  hreq;
    logic [7:0]  htrans_m;
    logic [11:0] hburst_m;
    logic        hready;
`ifdef AHB_ARB_HMASTLOCK_EN
    logic [3:0]  hmastlock_m;
`endif
    logic [3:0]  hgrant;
    logic        hsel_slv;
    logic [1:0]  addr_master_id;
    logic [1:0]  data_master_id;
    logic        data_valid;
    logic [3:0]  master_stall;

    int vecs = 0;
    int errs = 0;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter #(.MASTER_NUM(4)) dut (
        .hclk           (hclk),
        .hreset         (hreset),
        .hreq           (hreq),
        .htrans_m       (htrans_m),
        .hburst_m       (hburst_m),
        .hready         (hready),
`ifdef AHB_ARB_HMASTLOCK_EN
        .hmastlock_m    (hmastlock_m),
`endif
        .hgrant         (hgrant),
        .hsel_slv       (hsel_slv),
        .addr_master_id (addr_master_id),
        .data_master_id (data_master_id),
        .data_valid     (data_valid),
        .master_stall   (master_stall)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_m(input int m, input logic r, input logic [1:0] t, input logic [2:0] b);
        hreq[m]          = r;
        htrans_m[2*m +: 2] = t;
        hburst_m[3*m +: 3] = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] g, input logic [1:0] aid,
                          input logic [1:0] did, input logic dv);
        chk({tag, ".hgrant"}, 32'(hgrant), 32'(g));
        chk({tag, ".addr_id"}, 32'(addr_master_id), 32'(aid));
        chk({tag, ".data_id"}, 32'(data_master_id), 32'(did));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
    endtask

    initial begin
        hreset   = 1'b1;
        hready   = 1'b1;
        hreq     = '0;
        htrans_m = '0;
        hburst_m = '0;
`ifdef AHB_ARB_HMASTLOCK_EN
        hmastlock_m = '0;
`endif
        step();
        step();
        chk_st("reset", 4'b0000, 2'd0, 2'd0, 1'b0);
        chk("reset.hsel", 32'(hsel_slv), 32'd0);
        hreset = 1'b0;

        // 1) M0 and M2 SINGLE together: M0 first, M2 right after.
        set_m(0, 1'b1, NSQ, SINGLE);
        set_m(2, 1'b1, NSQ, SINGLE);
        #1;
        chk("t1.stall_pre", 32'(master_stall), 32'b0101);
        step();
        chk_st("t1a", 4'b0001, 2'd0, 2'd0, 1'b0);
        chk("t1a.stall", 32'(master_stall), 32'b0100);
        chk("t1a.hsel", 32'(hsel_slv), 32'd1);
        step();
        chk_st("t1b", 4'b0100, 2'd2, 2'd0, 1'b1);
        set_m(0, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t1c", 4'b0100, 2'd2, 2'd2, 1'b1);
        set_m(2, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t1d", 4'b0000, 2'd2, 2'd2, 1'b0);

        // 2) M1 INCR4 with M3 waiting: handover on the 4th beat edge.
        set_m(1, 1'b1, NSQ, INCR4);
        step();
        chk_st("t2a", 4'b0010, 2'd1, 2'd2, 1'b0);
        set_m(3, 1'b1, NSQ, SINGLE);
        step();
        chk_st("t2b", 4'b0010, 2'd1, 2'd1, 1'b1);
        chk("t2b.stall", 32'(master_stall), 32'b1000);
        set_m(1, 1'b1, SEQ, INCR4);
        step();
        chk_st("t2c", 4'b0010, 2'd1, 2'd1, 1'b1);
        step();
        chk_st("t2d", 4'b0010, 2'd1, 2'd1, 1'b1);
        step();
        chk_st("t2e", 4'b1000, 2'd3, 2'd1, 1'b1);
        set_m(1, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t2f", 4'b1000, 2'd3, 2'd3, 1'b1);
        set_m(3, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t2g", 4'b0000, 2'd3, 2'd3, 1'b0);

        // 3) M1 INCR4 with wait states on beat 2 and BUSY before beat 3, M0 waiting.
        set_m(1, 1'b1, NSQ, INCR4);
        step();
        chk_st("t3a", 4'b0010, 2'd1, 2'd3, 1'b0);
        step();
        chk_st("t3b", 4'b0010, 2'd1, 2'd1, 1'b1);
        set_m(1, 1'b1, SEQ, INCR4);
        set_m(0, 1'b1, NSQ, SINGLE);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st("t3wait", 4'b0010, 2'd1, 2'd1, 1'b1);
        end
        hready = 1'b1;
        step();
        chk_st("t3c", 4'b0010, 2'd1, 2'd1, 1'b1);
        set_m(1, 1'b1, BUSY, INCR4);
        step();
        chk_st("t3d", 4'b0010, 2'd1, 2'd1, 1'b0);
        set_m(1, 1'b1, SEQ, INCR4);
        step();
        chk_st("t3e", 4'b0010, 2'd1, 2'd1, 1'b1);
        step();
        chk_st("t3f", 4'b0001, 2'd0, 2'd1, 1'b1);
        set_m(1, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t3g", 4'b0001, 2'd0, 2'd0, 1'b1);
        set_m(0, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t3h", 4'b0000, 2'd0, 2'd0, 1'b0);

        // 4) M0 undefined-length INCR, 6 SEQ then IDLE, M2 waiting.
        set_m(0, 1'b1, NSQ, INCR);
        step();
        chk_st("t4a", 4'b0001, 2'd0, 2'd0, 1'b0);
        set_m(2, 1'b1, NSQ, SINGLE);
        step();
        chk_st("t4b", 4'b0001, 2'd0, 2'd0, 1'b1);
        set_m(0, 1'b1, SEQ, INCR);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_st("t4seq", 4'b0001, 2'd0, 2'd0, 1'b1);
        end
        set_m(0, 1'b0, IDLE, INCR);
        step();
        chk_st("t4c", 4'b0100, 2'd2, 2'd0, 1'b0);
        step();
        chk_st("t4d", 4'b0100, 2'd2, 2'd2, 1'b1);
        set_m(2, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t4e", 4'b0000, 2'd2, 2'd2, 1'b0);

        // 5) Reset during beat 2 of M3 INCR8, then M0 beats M3.
        set_m(3, 1'b1, NSQ, INCR8);
        step();
        chk_st("t5a", 4'b1000, 2'd3, 2'd2, 1'b0);
        step();
        chk_st("t5b", 4'b1000, 2'd3, 2'd3, 1'b1);
        set_m(3, 1'b1, SEQ, INCR8);
        hreset = 1'b1;
        step();
        chk_st("t5c", 4'b0000, 2'd0, 2'd0, 1'b0);
        hreset = 1'b0;
        set_m(3, 1'b1, NSQ, SINGLE);
        set_m(0, 1'b1, NSQ, SINGLE);
        step();
        chk_st("t5d", 4'b0001, 2'd0, 2'd0, 1'b0);
        set_m(0, 1'b0, IDLE, SINGLE);
        set_m(3, 1'b0, IDLE, SINGLE);
        step();
        chk_st("t5e", 4'b0000, 2'd0, 2'd0, 1'b0);

`ifdef AHB_ARB_HMASTLOCK_EN
        // 6) M2 locked SINGLEs keep the slave until hmastlock drops.
        set_m(2, 1'b1, NSQ, SINGLE);
        hmastlock_m = 4'b0100;
        step();
        chk_st("t6a", 4'b0100, 2'd2, 2'd0, 1'b0);
        set_m(0, 1'b1, NSQ, SINGLE);
        step();
        chk_st("t6b", 4'b0100, 2'd2, 2'd2, 1'b1);
        step();
        chk_st("t6c", 4'b0100, 2'd2, 2'd2, 1'b1);
        set_m(2, 1'b0, IDLE, SINGLE);
        hmastlock_m = 4'b0000;
        step();
        chk_st("t6d", 4'b0001, 2'd0, 2'd2, 1'b0);
        set_m(0, 1'b0, IDLE, SINGLE);
        step();
        chk("t6e.hgrant", 32'(hgrant), 32'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
